// File: rtl/sub_shift_rows.sv
`default_nettype none
// =====================================================================
// Module   : sub_shift_rows
// Brief    : Iterative AES SubBytes (LANES bytes per cycle) followed by
//            ShiftRows, with valid/ready handshake on both sides.
// Revision : 1.0 - initial release
// =====================================================================
module sub_shift_rows #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy
);

  localparam int c_STEPS = 16 / LANES;
  localparam int c_CNT_W = (c_STEPS > 1) ? $clog2(c_STEPS) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_STEPS - 1);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_SUB  = 2'd1;
  localparam logic [1:0] c_ST_DONE = 2'd2;

  // Forward S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] c_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] f_sbox(input logic [7:0] x);
    return c_SBOX[(255 - int'(x)) * 8 +: 8];
  endfunction

  logic [1:0]         r_fsm;
  logic [1:0]         w_fsm_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic [127:0]       r_state;
  logic [127:0]       w_state_sub;
  logic [7:0]         w_sub [LANES];
  logic               w_xfer;
  logic               w_last;

  assign w_xfer = in_valid & in_ready;
  assign w_last = (r_cnt == c_CNT_LAST);

  // One S-box per lane; lane l handles byte cnt*LANES + l.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign w_sub[l] = f_sbox(r_state[8 * (15 - (int'(r_cnt) * LANES + l)) +: 8]);
  end

  always_comb begin
    w_state_sub = r_state;
    for (int i = 0; i < LANES; i++) begin
      w_state_sub[8 * (15 - (int'(r_cnt) * LANES + i)) +: 8] = w_sub[i];
    end
  end

  // ShiftRows: out[row r][col c] = sub[row r][col (c+r) mod 4].
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign state_out[8 * (15 - (4 * c + r)) +: 8] =
        r_state[8 * (15 - (4 * ((c + r) % 4) + r)) +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm <= c_ST_IDLE;
    end else begin
      r_fsm <= w_fsm_nxt;
    end
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      c_ST_IDLE: if (w_xfer) w_fsm_nxt = c_ST_SUB;
      c_ST_SUB:  if (w_last) w_fsm_nxt = c_ST_DONE;
      c_ST_DONE: if (out_ready) w_fsm_nxt = in_valid ? c_ST_SUB : c_ST_IDLE;
      default:   w_fsm_nxt = c_ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_fsm)
      c_ST_IDLE: in_ready = 1'b1;
      c_ST_SUB:  busy = 1'b1;
      c_ST_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: in_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= '0;
      r_cnt   <= '0;
    end else if (w_xfer) begin
      r_state <= state_in;
      r_cnt   <= '0;
    end else if (r_fsm == c_ST_SUB) begin
      r_state <= w_state_sub;
      r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sub_shift_rows.sv
`default_nettype none
// =====================================================================
// Module   : tb_sub_shift_rows
// Brief    : Self-checking bench for sub_shift_rows at LANES = 4, 1, 16.
// Revision : 1.0 - initial release
// =====================================================================
module tb_sub_shift_rows;

  localparam logic [127:0] c_APPB_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] c_APPB_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] c_ZERO_OUT = {16{8'h63}};
  localparam logic [127:0] c_ONES_OUT = {16{8'h16}};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         iv   [3];
  logic         ordy [3];
  logic [127:0] sin  [3];
  logic         irdy [3];
  logic         ov   [3];
  logic         bz   [3];
  logic [127:0] sout [3];

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] ref_sb [256];

  always #5 clk = ~clk;

  sub_shift_rows #(.LANES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(irdy[0]), .state_in(sin[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .state_out(sout[0]), .busy(bz[0]));
  sub_shift_rows #(.LANES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(irdy[1]), .state_in(sin[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .state_out(sout[1]), .busy(bz[1]));
  sub_shift_rows #(.LANES(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(irdy[2]), .state_in(sin[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .state_out(sout[2]), .busy(bz[2]));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic int lat_of(input int d);
    return (d == 0) ? 4 : ((d == 1) ? 16 : 1);
  endfunction

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [7:0] v = b;
    for (int i = 0; i < n; i++) v = {v[6:0], v[7]};
    return v;
  endfunction

  // S-box from its definition: multiplicative inverse then affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      ref_sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] ref_ssr(input logic [127:0] din);
    logic [7:0]   m [4][4];
    logic [127:0] o = '0;
    for (int k = 0; k < 16; k++) m[k % 4][k / 4] = ref_sb[din[127 - 8 * k -: 8]];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127 - 8 * (4 * c + r) -: 8] = m[r][(c + r) % 4];
    return o;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d, input logic [127:0] din);
    int k = 0;
    while (!irdy[d] && k < 64) begin
      step();
      k++;
    end
    if (!irdy[d]) chk("send_timeout", {127'd0, irdy[d]}, 128'd1);
    sin[d] = din;
    iv[d]  = 1'b1;
    step();
    iv[d]  = 1'b0;
  endtask

  task automatic wait_out(input int d, output int cyc, output int bc);
    cyc = 0;
    bc  = 0;
    while (!ov[d] && cyc < 64) begin
      if (bz[d]) bc++;
      step();
      cyc++;
    end
  endtask

  task automatic consume(input int d);
    ordy[d] = 1'b1;
    step();
    ordy[d] = 1'b0;
  endtask

  task automatic run_vec(input int d, input logic [127:0] din, input logic [127:0] exp,
                         input string tag);
    int cyc, bc;
    send(d, din);
    wait_out(d, cyc, bc);
    chk({tag, "_data"}, sout[d], exp);
    chk({tag, "_latency"}, 128'(cyc), 128'(lat_of(d)));
    chk({tag, "_busy_cycles"}, 128'(bc), 128'(lat_of(d)));
    consume(d);
    chk({tag, "_valid_drop"}, {127'd0, ov[d]}, 128'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int cyc, bc, nres, t;
    logic [127:0] x;
    logic [127:0] res [2];
    int tm [2];

    for (int d = 0; d < 3; d++) begin
      iv[d] = 1'b0; ordy[d] = 1'b0; sin[d] = '0;
    end
    build_sbox();

    rst_n = 1'b0;
    step();
    step();
    for (int d = 0; d < 3; d++) begin
      chk("rst_out_valid", {127'd0, ov[d]}, 128'd0);
      chk("rst_busy", {127'd0, bz[d]}, 128'd0);
      chk("rst_in_ready", {127'd0, irdy[d]}, 128'd1);
      chk("rst_state_out", sout[d], 128'd0);
    end
    rst_n = 1'b1;
    step();

    for (int d = 0; d < 3; d++) begin
      run_vec(d, c_APPB_IN, c_APPB_OUT, "appb");
      run_vec(d, 128'd0, c_ZERO_OUT, "zeros");
      run_vec(d, '1, c_ONES_OUT, "ones");
    end

    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 8; i++) begin
        x = {$urandom, $urandom, $urandom, $urandom};
        run_vec(d, x, ref_ssr(x), "random");
      end
    end

    // Backpressure in DONE with a pending input.
    send(0, c_APPB_IN);
    wait_out(0, cyc, bc);
    chk("bp_first", sout[0], c_APPB_OUT);
    x = {$urandom, $urandom, $urandom, $urandom};
    sin[0] = x;
    iv[0]  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_valid", {127'd0, ov[0]}, 128'd1);
      chk("bp_in_ready", {127'd0, irdy[0]}, 128'd0);
      chk("bp_hold", sout[0], c_APPB_OUT);
    end
    ordy[0] = 1'b1;
    step();
    ordy[0] = 1'b0;
    iv[0]   = 1'b0;
    chk("bp_taken", {127'd0, bz[0]}, 128'd1);
    wait_out(0, cyc, bc);
    chk("bp_second", sout[0], ref_ssr(x));
    chk("bp_latency", 128'(cyc), 128'd4);
    consume(0);

    // Back-to-back with both sides always ready.
    sin[0] = c_APPB_IN;
    iv[0] = 1'b1;
    ordy[0] = 1'b1;
    step();
    sin[0] = '0;
    nres = 0;
    t = 0;
    while (nres < 2 && t < 40) begin
      if (ov[0]) begin
        res[nres] = sout[0];
        tm[nres] = t;
        nres++;
      end
      if (nres == 2) iv[0] = 1'b0;
      step();
      t++;
    end
    ordy[0] = 1'b0;
    iv[0] = 1'b0;
    chk("b2b_count", 128'(nres), 128'd2);
    if (nres == 2) begin
      chk("b2b_first", res[0], c_APPB_OUT);
      chk("b2b_second", res[1], c_ZERO_OUT);
      chk("b2b_first_time", 128'(tm[0]), 128'd4);
      chk("b2b_spacing", 128'(tm[1] - tm[0]), 128'd5);
    end
    chk("b2b_idle", {127'd0, irdy[0]}, 128'd1);

    // in_valid pulse during SUB must be ignored.
    send(0, c_APPB_IN);
    sin[0] = '1;
    iv[0] = 1'b1;
    step();
    iv[0] = 1'b0;
    wait_out(0, cyc, bc);
    chk("hyg_data", sout[0], c_APPB_OUT);
    chk("hyg_latency", 128'(cyc), 128'd3);
    consume(0);
    ordy[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hyg_idle_valid", {127'd0, ov[0]}, 128'd0);
    end
    ordy[0] = 1'b0;

    // Asynchronous reset two cycles into SUB.
    send(0, c_APPB_IN);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", {127'd0, ov[0]}, 128'd0);
    chk("mrst_busy", {127'd0, bz[0]}, 128'd0);
    chk("mrst_state_out", sout[0], 128'd0);
    chk("mrst_in_ready", {127'd0, irdy[0]}, 128'd1);
    step();
    rst_n = 1'b1;
    run_vec(0, c_APPB_IN, c_APPB_OUT, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
